// File: rtl/snn_pkg.sv
// snn_pkg: shared state type, drain length and address-width helper
// for the SNN timestep controller and its spike counter bank.
package snn_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      STREAM,
      DRAIN,
      SAMPLE,
      DONE
   } snn_ctrl_state_t;

   // memory latency + membrane update + PE compare register
   localparam int SNN_DRAIN_CYCLES = 3;
   localparam int SNN_DRAIN_W      = 2;

   function automatic int snn_addr_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/spike_counter_bank.sv
// spike_counter_bank: one saturating spike counter per neuron,
// cleared per inference and bumped on each sample strobe.
module spike_counter_bank
   import snn_pkg::*;
#(
   parameter int NUM_NEURONS = 8,
   parameter int CNT_W       = 8
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic                         clear,
   input  logic                         sample_en,
   input  logic [NUM_NEURONS-1:0]       spikes,
   output logic [NUM_NEURONS*CNT_W-1:0] counts
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   for (genvar n = 0; n < NUM_NEURONS; n++) begin : g_cnt
      logic [CNT_W-1:0] cnt;

      always_ff @(posedge clk or negedge rstn) begin
         if (!rstn) begin
            cnt <= '0;
         end else if (clear) begin
            cnt <= '0;
         end else if (sample_en && spikes[n] && (cnt != CNT_MAX)) begin
            cnt <= cnt + CNT_W'(1);
         end
      end

      assign counts[n*CNT_W +: CNT_W] = cnt;
   end

endmodule

// File: rtl/snn_timestep_ctrl.sv
// snn_timestep_ctrl: per-inference timestep sequencer for a PE row.
// Define SNN_CTRL_LEAK_RESET_EN to clear PE membranes every timestep.
module snn_timestep_ctrl
   import snn_pkg::*;
#(
   parameter int NUM_INPUTS  = 16,
   parameter int NUM_NEURONS = 8,
   parameter int TS_W        = 8,
   parameter int CNT_W       = 8
) (
   input  logic                                clk,
   input  logic                                rstn,
   input  logic                                start,
   input  logic [TS_W-1:0]                     num_steps,
   output logic                                busy,
   output logic                                done,
   output logic [snn_addr_w(NUM_INPUTS)-1:0]   spike_rd_addr,
   output logic                                spike_rd_en,
   input  logic                                spike_rd_data,
   output logic                                pe_rstn,
   output logic                                pe_valid,
   output logic                                pe_in_spike,
   output logic [snn_addr_w(NUM_INPUTS)-1:0]   w_addr,
   input  logic [NUM_NEURONS-1:0]              pe_out_spike,
   output logic [NUM_NEURONS*CNT_W-1:0]        spike_count
);

   localparam int AW = snn_addr_w(NUM_INPUTS);
   localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_INPUTS - 1);
   localparam logic [SNN_DRAIN_W-1:0] DRAIN_LAST =
      SNN_DRAIN_W'(SNN_DRAIN_CYCLES - 1);

`ifdef SNN_CTRL_LEAK_RESET_EN
   localparam snn_ctrl_state_t NEXT_STEP = CLEAR;
`else
   localparam snn_ctrl_state_t NEXT_STEP = STREAM;
`endif

   snn_ctrl_state_t        state_q;
   snn_ctrl_state_t        state_d;
   logic [TS_W-1:0]        steps_q;
   logic [TS_W-1:0]        step_cnt;
   logic [SNN_DRAIN_W-1:0] drain_cnt;
   logic                   rd_en_d;
   logic [AW-1:0]          rd_addr_d;
   logic                   accept;
   logic                   more_steps;
   logic                   sample_en;

   assign accept     = (state_q == IDLE) && start;
   assign sample_en  = (state_q == SAMPLE);
   assign more_steps = (step_cnt != (steps_q - TS_W'(1)));

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = (num_steps == '0) ? DONE : CLEAR;
            end
         end
         CLEAR: begin
            state_d = STREAM;
         end
         STREAM: begin
            if (spike_rd_addr == LAST_ADDR) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (drain_cnt == DRAIN_LAST) begin
               state_d = SAMPLE;
            end
         end
         SAMPLE: begin
            state_d = more_steps ? NEXT_STEP : DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= IDLE;
         steps_q   <= '0;
         step_cnt  <= '0;
         drain_cnt <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            steps_q  <= num_steps;
            step_cnt <= '0;
         end else if (sample_en) begin
            step_cnt <= step_cnt + TS_W'(1);
         end
         if (state_q == DRAIN) begin
            drain_cnt <= drain_cnt + SNN_DRAIN_W'(1);
         end else begin
            drain_cnt <= '0;
         end
      end
   end

   // control outputs registered from the next state so they track state_q
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         busy          <= 1'b0;
         done          <= 1'b0;
         pe_rstn       <= 1'b0;
         spike_rd_en   <= 1'b0;
         spike_rd_addr <= '0;
      end else begin
         busy        <= (state_d != IDLE);
         done        <= (state_d == DONE);
         pe_rstn     <= (state_d != IDLE) && (state_d != CLEAR);
         spike_rd_en <= (state_d == STREAM);
         if ((state_q == STREAM) && (state_d == STREAM)) begin
            spike_rd_addr <= spike_rd_addr + AW'(1);
         end else begin
            spike_rd_addr <= '0;
         end
      end
   end

   // rd_*_d tracks the read in flight; the PE side lands one cycle later
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rd_en_d     <= 1'b0;
         rd_addr_d   <= '0;
         pe_valid    <= 1'b0;
         pe_in_spike <= 1'b0;
         w_addr      <= '0;
      end else begin
         rd_en_d     <= spike_rd_en;
         rd_addr_d   <= spike_rd_addr;
         pe_valid    <= rd_en_d;
         pe_in_spike <= rd_en_d & spike_rd_data;
         w_addr      <= rd_en_d ? rd_addr_d : '0;
      end
   end

   spike_counter_bank #(
      .NUM_NEURONS (NUM_NEURONS),
      .CNT_W       (CNT_W)
   ) u_counters (
      .clk       (clk),
      .rstn      (rstn),
      .clear     (accept),
      .sample_en (sample_en),
      .spikes    (pe_out_spike),
      .counts    (spike_count)
   );

endmodule

// File: tb/tb_snn_timestep_ctrl.sv
// tb_snn_timestep_ctrl: randomized self-checking bench for the
// timestep controller against a cycle-count reference model.
`timescale 1ns/1ps
module tb_snn_timestep_ctrl;

   localparam int N     = 4;
   localparam int NN    = 8;
   localparam int TS_W  = 8;
   localparam int CNT_W = 2;
   localparam int AW    = 2;
   localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef SNN_CTRL_LEAK_RESET_EN
   localparam bit LEAK = 1'b1;
`else
   localparam bit LEAK = 1'b0;
`endif

   logic                  clk = 1'b0;
   logic                  rstn = 1'b0;
   logic                  start = 1'b0;
   logic [TS_W-1:0]       num_steps = '0;
   logic                  busy;
   logic                  done;
   logic [AW-1:0]         spike_rd_addr;
   logic                  spike_rd_en;
   logic                  spike_rd_data;
   logic                  pe_rstn;
   logic                  pe_valid;
   logic                  pe_in_spike;
   logic [AW-1:0]         w_addr;
   logic [NN-1:0]         pe_out_spike = '0;
   logic [NN*CNT_W-1:0]   spike_count;

   logic [N-1:0]  spike_mem = '0;
   logic [NN-1:0] pat [64];

   int n_tests = 0;
   int n_fail  = 0;
   int r_done_cyc, r_done_cnt, r_busy, r_valid, r_bad, r_clr;

   always #5 clk = ~clk;

   snn_timestep_ctrl #(
      .NUM_INPUTS  (N),
      .NUM_NEURONS (NN),
      .TS_W        (TS_W),
      .CNT_W       (CNT_W)
   ) dut (
      .clk           (clk),
      .rstn          (rstn),
      .start         (start),
      .num_steps     (num_steps),
      .busy          (busy),
      .done          (done),
      .spike_rd_addr (spike_rd_addr),
      .spike_rd_en   (spike_rd_en),
      .spike_rd_data (spike_rd_data),
      .pe_rstn       (pe_rstn),
      .pe_valid      (pe_valid),
      .pe_in_spike   (pe_in_spike),
      .w_addr        (w_addr),
      .pe_out_spike  (pe_out_spike),
      .spike_count   (spike_count)
   );

   // spike buffer with one cycle of read latency
   always @(posedge clk or negedge rstn) begin
      if (!rstn) spike_rd_data <= 1'b0;
      else spike_rd_data <= spike_rd_en ? spike_mem[spike_rd_addr] : 1'b0;
   end

   function automatic int exp_done(input int s);
      if (s == 0) return 1;
      return LEAK ? 1 + s * (N + 5) : 2 + s * (N + 4);
   endfunction

   function automatic int exp_clr(input int s);
      if (s == 0) return 0;
      return LEAK ? s : 1;
   endfunction

   function automatic int samp_step(input int c);
      int ts;
      int off;
      ts  = LEAK ? N + 5 : N + 4;
      off = LEAK ? 0 : 1;
      if ((c - off) <= 0 || ((c - off) % ts) != 0) return -1;
      return (c - off) / ts - 1;
   endfunction

   function automatic int model_count(input int n, input int s);
      int sum;
      sum = 0;
      for (int t = 0; t < s; t++) if (pat[t][n]) sum++;
      return (sum > CMAX) ? CMAX : sum;
   endfunction

   // drives one inference and records what the outputs did, cycle by cycle
   task automatic run_inf(input int steps, input bit poke);
      int budget;
      int vrun;
      int rrun;
      int t;
      r_done_cyc = -1;
      r_done_cnt = 0;
      r_busy = 0;
      r_valid = 0;
      r_bad = 0;
      r_clr = 0;
      vrun = 0;
      rrun = 0;
      budget = exp_done(steps) + 20;
      @(negedge clk);
      start = 1'b1;
      num_steps = TS_W'(steps);
      @(posedge clk);
      #1;
      start = 1'b0;
      num_steps = TS_W'($urandom);
      for (int cyc = 1; cyc <= budget; cyc++) begin
         if (done) begin
            r_done_cnt++;
            if (r_done_cyc < 0) r_done_cyc = cyc;
         end
         if (busy) r_busy++;
         if (busy && !pe_rstn) r_clr++;
         if (pe_valid) begin
            r_valid++;
            if (vrun >= N || !pe_rstn) r_bad++;
            else if (w_addr !== AW'(vrun) || pe_in_spike !== spike_mem[vrun]) r_bad++;
            vrun++;
         end else begin
            if (vrun != 0 && vrun != N) r_bad++;
            vrun = 0;
         end
         if (spike_rd_en) begin
            if (rrun >= N || spike_rd_addr !== AW'(rrun)) r_bad++;
            rrun++;
         end else begin
            if (rrun != 0 && rrun != N) r_bad++;
            rrun = 0;
         end
         t = samp_step(cyc);
         if (t >= 0 && t < steps) pe_out_spike = pat[t];
         else pe_out_spike = NN'($urandom);
         if (poke && cyc >= 2 && cyc < exp_done(steps) && $urandom_range(0, 2) == 0) begin
            start = 1'b1;
            num_steps = TS_W'($urandom);
         end else begin
            start = 1'b0;
         end
         if (r_done_cyc > 0 && cyc >= r_done_cyc + 3) break;
         @(posedge clk);
         #1;
      end
      start = 1'b0;
      pe_out_spike = '0;
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      #12;
      n_tests++;
      if ({busy, done, pe_rstn, pe_valid, pe_in_spike, spike_rd_en} !== 6'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b want 000000",
                  {busy, done, pe_rstn, pe_valid, pe_in_spike, spike_rd_en});
      end
      n_tests++;
      if ({spike_rd_addr, w_addr, spike_count} !== '0) begin
         n_fail++;
         $display("FAIL reset_data: addr %0d w %0d cnt %h want 0", spike_rd_addr, w_addr, spike_count);
      end
      @(negedge clk);
      rstn = 1'b1;
      repeat (2) @(negedge clk);
      n_tests++;
      if ({busy, pe_rstn, pe_valid} !== 3'b0) begin
         n_fail++;
         $display("FAIL idle_after_reset: got %b want 000", {busy, pe_rstn, pe_valid});
      end
   endtask

   task automatic test_single_step();
      spike_mem = '1;
      pat[0] = 8'hFF;
      run_inf(1, 1'b0);
      n_tests++;
      if (r_done_cyc != 10) begin
         n_fail++;
         $display("FAIL single_done_cycle: got %0d want 10", r_done_cyc);
      end
      n_tests++;
      if (r_valid != 4 || r_bad != 0) begin
         n_fail++;
         $display("FAIL single_stream: valid %0d bad %0d want 4/0", r_valid, r_bad);
      end
      n_tests++;
      if (r_busy != 10 || r_done_cnt != 1) begin
         n_fail++;
         $display("FAIL single_busy: busy %0d dones %0d want 10/1", r_busy, r_done_cnt);
      end
      for (int n = 0; n < NN; n++) begin
         n_tests++;
         if (spike_count[n*CNT_W +: CNT_W] !== CNT_W'(1)) begin
            n_fail++;
            $display("FAIL single_count[%0d]: got %0d want 1", n, spike_count[n*CNT_W +: CNT_W]);
         end
      end
   endtask

   task automatic test_multi_step();
      spike_mem = N'($urandom);
      for (int t = 0; t < 3; t++) pat[t] = 8'b0000_0101;
      run_inf(3, 1'b0);
      n_tests++;
      if (r_done_cyc != exp_done(3) || r_clr != exp_clr(3)) begin
         n_fail++;
         $display("FAIL multi_timing: done %0d clr %0d want %0d/%0d",
                  r_done_cyc, r_clr, exp_done(3), exp_clr(3));
      end
      n_tests++;
      if (r_valid != 3 * N || r_bad != 0) begin
         n_fail++;
         $display("FAIL multi_stream: valid %0d bad %0d want %0d/0", r_valid, r_bad, 3 * N);
      end
      n_tests++;
      if (spike_count !== 16'h0033) begin
         n_fail++;
         $display("FAIL multi_counts: got %h want 0033", spike_count);
      end
   endtask

   task automatic test_saturation();
      spike_mem = N'($urandom);
      for (int t = 0; t < 5; t++) pat[t] = NN'($urandom) | 8'h01;
      run_inf(5, 1'b0);
      n_tests++;
      if (spike_count[CNT_W-1:0] !== CNT_W'(3)) begin
         n_fail++;
         $display("FAIL sat_count0: got %0d want 3", spike_count[CNT_W-1:0]);
      end
      for (int n = 1; n < NN; n++) begin
         n_tests++;
         if (spike_count[n*CNT_W +: CNT_W] !== CNT_W'(model_count(n, 5))) begin
            n_fail++;
            $display("FAIL sat_count[%0d]: got %0d want %0d",
                     n, spike_count[n*CNT_W +: CNT_W], model_count(n, 5));
         end
      end
   endtask

   task automatic test_zero_steps();
      run_inf(0, 1'b0);
      n_tests++;
      if (r_done_cyc != 1 || r_done_cnt != 1) begin
         n_fail++;
         $display("FAIL zero_done: cycle %0d dones %0d want 1/1", r_done_cyc, r_done_cnt);
      end
      n_tests++;
      if (r_busy != 1 || r_valid != 0 || r_clr != 0) begin
         n_fail++;
         $display("FAIL zero_activity: busy %0d valid %0d clr %0d want 1/0/0", r_busy, r_valid, r_clr);
      end
      n_tests++;
      if (spike_count !== '0) begin
         n_fail++;
         $display("FAIL zero_counts: got %h want 0", spike_count);
      end
   endtask

   task automatic test_start_while_busy();
      spike_mem = N'($urandom);
      for (int t = 0; t < 2; t++) pat[t] = NN'($urandom);
      run_inf(2, 1'b1);
      n_tests++;
      if (r_done_cnt != 1 || r_done_cyc != exp_done(2)) begin
         n_fail++;
         $display("FAIL busy_ignore: dones %0d at %0d want 1 at %0d", r_done_cnt, r_done_cyc, exp_done(2));
      end
      for (int n = 0; n < NN; n++) begin
         n_tests++;
         if (spike_count[n*CNT_W +: CNT_W] !== CNT_W'(model_count(n, 2))) begin
            n_fail++;
            $display("FAIL busy_count[%0d]: got %0d want %0d",
                     n, spike_count[n*CNT_W +: CNT_W], model_count(n, 2));
         end
      end
   endtask

   task automatic test_reset_mid_stream();
      @(negedge clk);
      start = 1'b1;
      num_steps = TS_W'(4);
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #3;
      n_tests++;
      if (busy !== 1'b1 || spike_rd_en !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_stream_active: busy %b rd_en %b want 1/1", busy, spike_rd_en);
      end
      rstn = 1'b0;
      #1;
      n_tests++;
      if ({busy, done, pe_rstn, pe_valid, pe_in_spike, spike_rd_en} !== 6'b0 ||
          {spike_rd_addr, w_addr, spike_count} !== '0) begin
         n_fail++;
         $display("FAIL async_reset: ctrl %b addr %0d w %0d want all 0",
                  {busy, done, pe_rstn, pe_valid, pe_in_spike, spike_rd_en}, spike_rd_addr, w_addr);
      end
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b1;
      spike_mem = N'($urandom);
      for (int t = 0; t < 2; t++) pat[t] = NN'($urandom);
      run_inf(2, 1'b0);
      n_tests++;
      if (r_done_cyc != exp_done(2) || r_valid != 2 * N || r_bad != 0) begin
         n_fail++;
         $display("FAIL post_reset_run: done %0d valid %0d bad %0d want %0d/%0d/0",
                  r_done_cyc, r_valid, r_bad, exp_done(2), 2 * N);
      end
   endtask

   task automatic test_random();
      int s;
      for (int k = 0; k < 8; k++) begin
         s = $urandom_range(1, 6);
         spike_mem = N'($urandom);
         for (int t = 0; t < s; t++) pat[t] = NN'($urandom);
         run_inf(s, 1'b0);
         n_tests++;
         if (r_done_cyc != exp_done(s) || r_done_cnt != 1 || r_busy != exp_done(s)) begin
            n_fail++;
            $display("FAIL rand%0d_timing: done %0d x%0d busy %0d want %0d",
                     k, r_done_cyc, r_done_cnt, r_busy, exp_done(s));
         end
         n_tests++;
         if (r_valid != s * N || r_bad != 0 || r_clr != exp_clr(s)) begin
            n_fail++;
            $display("FAIL rand%0d_stream: valid %0d bad %0d clr %0d want %0d/0/%0d",
                     k, r_valid, r_bad, r_clr, s * N, exp_clr(s));
         end
         for (int n = 0; n < NN; n++) begin
            n_tests++;
            if (spike_count[n*CNT_W +: CNT_W] !== CNT_W'(model_count(n, s))) begin
               n_fail++;
               $display("FAIL rand%0d_count[%0d]: got %0d want %0d",
                        k, n, spike_count[n*CNT_W +: CNT_W], model_count(n, s));
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_step();
      test_multi_step();
      test_saturation();
      test_zero_steps();
      test_start_while_busy();
      test_reset_mid_stream();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/snn_timestep_ctrl.md
# snn_timestep_ctrl

Sequencer for a row of fixed-point spiking PEs. Per inference it runs `num_steps` timesteps. Each timestep streams all `NUM_INPUTS` input spikes from the spike buffer into the PE row, waits for the PE pipeline to settle, then samples the PE output spikes into per-neuron saturating spike counters. It sits between the host-side start/done handshake and the PE array. It owns the PE clear, the input address generation and the result counters.

## Interface
Parameters:
- `NUM_INPUTS`, 16: input lines (spikes) streamed per timestep; ≥2.
- `NUM_NEURONS`, 8: PEs in the row.
- `TS_W`, 8: width of `num_steps`.
- `CNT_W`, 8: width of each per-neuron spike counter.

Ports:
- `clk`, in, 1: the single clock.
- `rstn`, in, 1: reset, asynchronous and active-low.
- `start`, in, 1: inference request; honoured only in IDLE.
- `num_steps`, in, TS_W: timesteps to run; sampled on accepted `start`.
- `busy`, out, 1: high from the accepted `start` until DONE is left.
- `done`, out, 1: single-cycle pulse when the inference completes.
- `spike_rd_addr`, out, $clog2(NUM_INPUTS): spike buffer read address. The buffer has 1-cycle read latency.
- `spike_rd_en`, out, 1: read strobe.
- `spike_rd_data`, in, 1: spike bit, valid the cycle after `spike_rd_en`.
- `pe_rstn`, out, 1: active-low clear to all PEs (membrane and out_spike).
- `pe_valid`, out, 1: PE input qualifier. When low, the array weight mux presents weight 0 and spike 1, so the PEs add zero.
- `pe_in_spike`, out, 1: spike to all PEs.
- `w_addr`, out, $clog2(NUM_INPUTS): weight-row address, aligned with `pe_in_spike`.
- `pe_out_spike`, in, NUM_NEURONS: registered PE outputs.
- `spike_count`, out, NUM_NEURONS*CNT_W: counter for neuron n in bits [n*CNT_W +: CNT_W].

## Operation
- States: IDLE, CLEAR, STREAM, DRAIN, SAMPLE, DONE.
- IDLE:
  - `pe_rstn`=0, `busy`=0.
  - `start`=1 latches `num_steps`, zeroes all counters and moves to CLEAR, or to DONE if `num_steps`=0.
- CLEAR: one cycle with `pe_rstn`=0. Resets the timestep counter on first entry, then moves to STREAM.
- STREAM:
  - NUM_INPUTS cycles; `spike_rd_en`=1 and `spike_rd_addr` = 0..NUM_INPUTS-1 in order.
  - `pe_valid`, `pe_in_spike`=`spike_rd_data` and `w_addr` are registered one cycle behind the read.
- DRAIN: 3 cycles. Covers 1 memory latency, 1 membrane update and 1 PE compare register.
- SAMPLE: one cycle.
  - Each counter n increments if `pe_out_spike[n]`, saturating at 2^CNT_W-1.
  - The timestep counter increments.
  - If steps remain, go to STREAM (or CLEAR, see Configuration); else go to DONE.
- DONE: `done`=1 for one cycle, then IDLE. `spike_count` holds until the next accepted `start`.
- `start` while `busy` is ignored. `num_steps` changes after acceptance have no effect.
- Async reset at any point:
  - Immediately IDLE.
  - `busy`=`done`=`spike_rd_en`=`pe_valid`=0, `pe_rstn`=0, all counters 0, addresses 0.

## Timing
- Reset values: `busy`=0, `done`=0, `pe_rstn`=0, `pe_valid`=0, `pe_in_spike`=0, `spike_rd_en`=0, `spike_rd_addr`=0, `w_addr`=0, `spike_count`=0.
- `start` sampled at edge 0; CLEAR occupies cycle 1; STREAM occupies cycles 2..NUM_INPUTS+1.
- `pe_valid` is high for exactly NUM_INPUTS consecutive cycles per timestep.
- Timestep length is NUM_INPUTS+4 cycles (+1 with the leak-reset option).
- `done` asserts at cycle 2 + num_steps*(NUM_INPUTS+4) for the default build.
- `num_steps`=0: `done` at cycle 1; counters read 0.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- Macro: `SNN_CTRL_LEAK_RESET_EN`.
- Defined: SAMPLE with steps remaining goes to CLEAR. PE membranes are cleared at every timestep boundary (reset-to-zero neuron), and the timestep length becomes NUM_INPUTS+5.
- Undefined: SAMPLE goes straight to STREAM. Membranes accumulate across the whole inference and are cleared only at inference start.

## Structure
- Shared package `snn_pkg`:
  - state enum `snn_ctrl_state_t`;
  - constant `SNN_DRAIN_CYCLES`=3;
  - the address-width helper.
- One natural sub-module: `spike_counter_bank`, NUM_NEURONS saturating CNT_W counters with clear and sample-enable inputs.

## Test plan
- NUM_INPUTS=4, num_steps=1, all spikes 1, `pe_out_spike`=8'hFF at SAMPLE:
  - `pe_valid` high 4 cycles, addresses 0,1,2,3;
  - `done` at cycle 10;
  - all counts = 1.
- num_steps=3, `pe_out_spike`=8'b0000_0101 on every SAMPLE: counts[0]=counts[2]=3, all others 0.
- CNT_W=2, num_steps=5, neuron 0 spiking every timestep: count[0] saturates at 3.
- num_steps=0: `done` pulse at cycle 1, `busy` high 1 cycle, `pe_valid` never asserts.
- `start` re-asserted while `busy`: ignored; a single `done`. Then `rstn` dropped mid-STREAM: outputs reach reset values asynchronously; the next `start` runs cleanly.
- With `SNN_CTRL_LEAK_RESET_EN`, num_steps=2: `pe_rstn` is low for one cycle before each STREAM (2 pulses), and the timestep length is NUM_INPUTS+5.
